cla_multiword_seq: RTL and testbench

//  Sequencer that performs WORDS*8-bit add/subtract by time-multiplexing a single 8-bit CLA slice.

---
 rtl/cla_pkg.sv | 10 +
 rtl/cla_multiword_seq_if.sv | 28 ++
 rtl/cla_structural.sv | 39 +++
 rtl/cla_multiword_seq.sv | 144 ++++++++++++++
 tb/tb_cla_multiword_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the multi-word CLA sequencer: slice width and FSM state codes.
package cla_pkg;

  localparam int SLICE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_multiword_seq_if.sv
// Host-side bus of the multi-word add/subtract sequencer: request, operands and result.
interface cla_multiword_seq_if #(parameter int WORDS = 4);

  localparam int W = cla_pkg::SLICE_W * WORDS;

  logic         start;
  logic         sub;
  logic         abort;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, abort, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, abort, cin, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/cla_structural.sv
// 8-bit carry-lookahead adder slice; every carry is a flat sum of generate/propagate products.
module cla_structural
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;
  logic               term;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, expanded without rippling
  always_comb begin
    c    = '0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i];
      term   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (term & g[j]);
        term   = term & p[j];
      end
      c[i+1] = c[i+1] | (term & cin);
    end
  end

  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_multiword_seq.sv
// Multi-word add/subtract that time-multiplexes one 8-bit CLA slice, LSB slice first.
//   state   | meaning
//   IDLE    | waiting for start; result registers hold the last outcome
//   RUN     | one slice per cycle, carry registered between slices
//   DONE    | single-cycle done pulse, then back to IDLE
module cla_multiword_seq
  import cla_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_multiword_seq_if.slave  bus
);

  localparam int                W     = SLICE_W * WORDS;
  localparam int                IDX_W = $clog2(WORDS) + 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(WORDS - 1);

  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic               sub_r;
  logic               carry;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               busy;
  logic               done;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               ovf_nx;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IDX_W'(w)) begin
        slice_a = a_r[w*SLICE_W +: SLICE_W];
        slice_b = sub_r ? ~b_r[w*SLICE_W +: SLICE_W] : b_r[w*SLICE_W +: SLICE_W];
      end
    end
  end

  cla_structural u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // a^b^sum at the MSB recovers the carry into the MSB
  assign ovf_nx = slice_cout ^ (slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_sum[SLICE_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_RUN;
      ST_RUN: begin
        if (bus.abort)        state_nx = ST_IDLE;
        else if (idx == LAST) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sub_r  <= 1'b0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            sub_r  <= bus.sub;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
          end else begin
            for (int w = 0; w < WORDS; w++) begin
              if (idx == IDX_W'(w)) sum_r[w*SLICE_W +: SLICE_W] <= slice_sum;
            end
            carry <= slice_cout;
            if (idx == LAST) begin
              cout_r <= slice_cout;
              ovf_r  <= ovf_nx;
              idx    <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed bench for the 4-word CLA sequencer; expected results come from a scoreboard queue.
module tb_cla_multiword_seq;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];
  exp_t last;

  cla_multiword_seq_if #(.WORDS(4)) bus ();

  cla_multiword_seq #(.WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                                 input logic ci);
    exp_t        e;
    logic [31:0] be;
    logic [32:0] r;
    be     = s ? ~bb : bb;
    r      = {1'b0, aa} + {1'b0, be} + {32'd0, (s ? 1'b1 : ci)};
    e.sum  = r[31:0];
    e.cout = r[32];
    e.ovf  = (aa[31] == be[31]) && (r[31] != aa[31]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation in the current cycle and follows it to the done pulse.
  task automatic run_op(input string tag, input logic s, input logic [31:0] aa,
                        input logic [31:0] bb, input logic ci, input bit extra);
    int   cyc;
    bit   seen;
    exp_t e;
    bus.sub   = s;
    bus.a     = aa;
    bus.b     = bb;
    bus.cin   = ci;
    bus.start = 1'b1;
    sb.push_back(model(s, aa, bb, ci));
    tick();
    cyc  = 1;
    seen = 1'b0;
    check({tag, "_busy_c1"}, 64'(bus.busy), 64'd1);
    while (cyc <= 12) begin
      bus.start = extra && (cyc == 2 || cyc == 5);
      if (extra && cyc == 2) begin
        bus.a = ~aa;
        bus.b = aa;
      end
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'd5);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_sum"}, 64'(bus.sum), 64'(e.sum));
    check({tag, "_cout"}, 64'(bus.cout), 64'(e.cout));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
    tick();
    bus.start = 1'b0;
    bus.a     = aa;
    bus.b     = bb;
    check({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    check({tag, "_hold"}, 64'({bus.sum, bus.cout, bus.ovf}), 64'(e));
    last = e;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.abort = 1'b0;
    bus.cin   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check("rst_outputs", 64'({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf}), 64'd0);
    rst_n = 1'b1;
    tick();

    // carry out of byte 0 into byte 1
    run_op("add_ff_1", 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("add_ff_1_const", 64'(last.sum), 64'h0000_0100);
    // carry ripples through all four slices
    run_op("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("add_wrap_const", 64'({last.sum, last.cout, last.ovf}), 64'({32'h0, 1'b1, 1'b0}));
    run_op("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    check("sub_ovf_const", 64'({last.sum, last.cout, last.ovf}), 64'({32'h7FFF_FFFF, 1'b1, 1'b1}));

    // reset mid-RUN, after slice 0 has been written
    bus.sub   = 1'b0;
    bus.a     = 32'h1234_5611;
    bus.b     = 32'h0000_0022;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("partial_sum_c2", 64'(bus.sum), 64'h0000_0033);
    rst_n = 1'b0;
    #1;
    check("rst_mid_run", 64'({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf}), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_op("after_rst", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);

    run_op("add_cin", 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0);
    run_op("sub_cin_ign", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0);
    run_op("sub_cin_ign1", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);

    // starts in RUN and DONE are dropped
    run_op("ign_start", 1'b0, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b1);
    tick();
    check("ign_no_done", 64'({bus.busy, bus.done}), 64'd0);
    check("ign_sum_kept", 64'(bus.sum), 64'(last.sum));

    // abort in cycle 3 of an operation, then a back-to-back start
    bus.sub   = 1'b0;
    bus.a     = 32'hAAAA_AAAA;
    bus.b     = 32'h5555_5556;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_idle", 64'({bus.busy, bus.done}), 64'd0);
    check("abort_clear", 64'({bus.sum, bus.cout, bus.ovf}), 64'd0);
    run_op("post_abort", 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);

    // abort while idle is harmless
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_idle_nop", 64'({bus.sum, bus.cout, bus.ovf}), 64'(last));

    for (int k = 0; k < 4; k++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom),
             1'($urandom_range(0, 1)), 1'b0);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
